// File: rtl/rps_game_if.sv
// Button inputs and doll/score outputs of the rock-paper-scissors game sequencer.
// The controller takes the slave modport; the button source and observer take master.
interface rps_game_if;
    logic       btn_start;
    logic       btn_rock;
    logic       btn_paper;
    logic       btn_scissors;
    logic [2:0] doll_state;
    logic [1:0] player_move;
    logic [1:0] doll_move;
    logic [3:0] player_score;
    logic [3:0] doll_score;
    logic       result_valid;

    modport master (
        output btn_start, btn_rock, btn_paper, btn_scissors,
        input  doll_state, player_move, doll_move, player_score, doll_score, result_valid
    );

    modport slave (
        input  btn_start, btn_rock, btn_paper, btn_scissors,
        output doll_state, player_move, doll_move, player_score, doll_score, result_valid
    );
endinterface

// File: rtl/rps_game_controller.sv
// Rock-paper-scissors game sequencer: press detection, round timing, doll move pick,
// scoring, and the doll_state code that feeds the servo driver.
module rps_game_controller #(
    parameter logic [31:0] COUNT_TICKS  = 32'd300_000_000,
    parameter logic [31:0] RESULT_TICKS = 32'd200_000_000,
    parameter logic [31:0] IDLE_TICKS   = 32'd500_000_000,
    parameter logic [3:0]  SCORE_MAX    = 4'd5,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic       clk,
    input  logic       rst,
    rps_game_if.slave  io
);

    typedef enum logic [2:0] {
        S_ATTRACT,
        S_READY,
        S_COUNT,
        S_RESULT,
        S_OVER
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] timer_q, timer_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [3:0]  btn_q, btn_d;
    logic [2:0]  doll_state_q, doll_state_d;
    logic [1:0]  player_move_q, player_move_d;
    logic [1:0]  doll_move_q, doll_move_d;
    logic [3:0]  player_score_q, player_score_d;
    logic [3:0]  doll_score_q, doll_score_d;
    logic        result_valid_q, result_valid_d;

    logic [3:0]  rise;
    logic        start_press;
    logic [1:0]  move_press;
    logic [1:0]  doll_pick;
    logic [1:0]  round_move;
    logic        player_wins;
    logic        timer_zero;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v >= SCORE_MAX) ? v : v + 4'd1;
    endfunction

    assign btn_d       = {io.btn_start, io.btn_rock, io.btn_paper, io.btn_scissors};
    assign rise        = btn_d & ~btn_q;
    assign start_press = rise[3];
    assign lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign doll_pick   = 2'(lfsr_q % 16'd3) + 2'd1;
    assign timer_zero  = (timer_q == 32'd0);

    // A press arriving in the expiry cycle itself still counts for this round.
    assign round_move  = (player_move_q != 2'd0) ? player_move_q : move_press;
    assign player_wins = (round_move == 2'd1 && doll_pick == 2'd3) ||
                         (round_move == 2'd2 && doll_pick == 2'd1) ||
                         (round_move == 2'd3 && doll_pick == 2'd2);

    // Simultaneous move rises are ambiguous and treated as no press.
    always_comb begin
        move_press = 2'd0;
        case (rise[2:0])
            3'b100:  move_press = 2'd1;
            3'b010:  move_press = 2'd2;
            3'b001:  move_press = 2'd3;
            default: move_press = 2'd0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        timer_d        = timer_q;
        doll_state_d   = doll_state_q;
        player_move_d  = player_move_q;
        doll_move_d    = doll_move_q;
        player_score_d = player_score_q;
        doll_score_d   = doll_score_q;
        result_valid_d = 1'b0;
        case (state_q)
            S_ATTRACT: begin
                if (start_press || move_press != 2'd0) begin
                    state_d      = S_READY;
                    timer_d      = IDLE_TICKS;
                    doll_state_d = 3'd2;
                end
            end
            S_READY: begin
                if (start_press) begin
                    state_d       = S_COUNT;
                    timer_d       = COUNT_TICKS;
                    player_move_d = 2'd0;
                    doll_move_d   = 2'd0;
                    doll_state_d  = 3'd3;
                end else if (timer_zero) begin
                    state_d      = S_ATTRACT;
                    doll_state_d = 3'd1;
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_COUNT: begin
                if (player_move_q == 2'd0 && move_press != 2'd0) player_move_d = move_press;
                if (timer_zero) begin
                    state_d        = S_RESULT;
                    timer_d        = RESULT_TICKS;
                    doll_move_d    = doll_pick;
                    result_valid_d = 1'b1;
                    if (round_move == 2'd0) begin
                        doll_state_d = 3'd5;
                        doll_score_d = sat_inc(doll_score_q);
                    end else if (round_move == doll_pick) begin
                        doll_state_d = 3'd4;
                    end else if (player_wins) begin
                        doll_state_d   = 3'd7;
                        player_score_d = sat_inc(player_score_q);
                    end else begin
                        doll_state_d = 3'd6;
                        doll_score_d = sat_inc(doll_score_q);
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_RESULT: begin
                if (timer_zero) begin
                    if (player_score_q == SCORE_MAX || doll_score_q == SCORE_MAX) begin
                        state_d      = S_OVER;
                        doll_state_d = (player_score_q == SCORE_MAX) ? 3'd7 : 3'd6;
                    end else begin
                        state_d      = S_READY;
                        timer_d      = IDLE_TICKS;
                        doll_state_d = 3'd2;
                    end
                end else begin
                    timer_d = timer_q - 32'd1;
                end
            end
            S_OVER: begin
                if (start_press) begin
                    state_d        = S_READY;
                    timer_d        = IDLE_TICKS;
                    player_score_d = 4'd0;
                    doll_score_d   = 4'd0;
                    doll_state_d   = 3'd2;
                end
            end
            default: begin
                state_d      = S_ATTRACT;
                doll_state_d = 3'd1;
            end
        endcase
    end

    // History resets high so a button held through reset is not taken as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_ATTRACT;
            timer_q        <= 32'd0;
            lfsr_q         <= LFSR_SEED;
            btn_q          <= 4'b1111;
            doll_state_q   <= 3'd1;
            player_move_q  <= 2'd0;
            doll_move_q    <= 2'd0;
            player_score_q <= 4'd0;
            doll_score_q   <= 4'd0;
            result_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            lfsr_q         <= lfsr_d;
            btn_q          <= btn_d;
            doll_state_q   <= doll_state_d;
            player_move_q  <= player_move_d;
            doll_move_q    <= doll_move_d;
            player_score_q <= player_score_d;
            doll_score_q   <= doll_score_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign io.doll_state   = doll_state_q;
    assign io.player_move  = player_move_q;
    assign io.doll_move    = doll_move_q;
    assign io.player_score = player_score_q;
    assign io.doll_score   = doll_score_q;
    assign io.result_valid = result_valid_q;

endmodule

// File: tb/tb_rps_game_controller.sv
// Self-checking bench for rps_game_controller with shrunk timers, a per-cycle
// reference model, a vector table and directed multi-cycle sequences.
module tb_rps_game_controller;

    localparam int CNT  = 20;
    localparam int RES  = 10;
    localparam int IDLE = 50;
    localparam int SMAX = 2;
    localparam int SEED = 'hACE1;

    localparam int P_ATT = 0, P_RDY = 1, P_CNT = 2, P_RES = 3, P_OVR = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    rps_game_if bus ();

    rps_game_controller #(
        .COUNT_TICKS (32'd20),
        .RESULT_TICKS(32'd10),
        .IDLE_TICKS  (32'd50),
        .SCORE_MAX   (4'd2),
        .LFSR_SEED   (16'hACE1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    int checks = 0;
    int errors = 0;
    int n_ds3  = 0;
    int n_rv   = 0;

    int m_phase = P_ATT, m_left = 0, m_lfsr = SEED;
    int m_ds = 1, m_pm = 0, m_dm = 0, m_psc = 0, m_dsc = 0, m_rv = 0;
    int pv_s = 1, pv_r = 1, pv_p = 1, pv_x = 1;

    typedef struct {
        logic s, r, p, x;
        int   ds;
        int   pm;
    } vec_t;
    vec_t tbl[12];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40) $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int lfsr_adv(input int l, input int n);
        int v = l;
        for (int i = 0; i < n; i++) begin
            int fb = ((v >> 15) ^ (v >> 13) ^ (v >> 12) ^ (v >> 10)) & 1;
            v = ((v << 1) | fb) & 'hFFFF;
        end
        return v;
    endfunction

    task automatic model_step(input logic s, r, p, x, rs);
        int sp, rk, pk, sk, mv, dp;
        if (rs) begin
            m_phase = P_ATT; m_left = 0; m_lfsr = SEED;
            m_ds = 1; m_pm = 0; m_dm = 0; m_psc = 0; m_dsc = 0; m_rv = 0;
            pv_s = 1; pv_r = 1; pv_p = 1; pv_x = 1;
            return;
        end
        sp = (s && pv_s == 0) ? 1 : 0;
        rk = (r && pv_r == 0) ? 1 : 0;
        pk = (p && pv_p == 0) ? 1 : 0;
        sk = (x && pv_x == 0) ? 1 : 0;
        mv = 0;
        if (rk + pk + sk == 1) mv = rk ? 1 : (pk ? 2 : 3);
        m_rv = 0;
        case (m_phase)
            P_ATT: begin
                if (sp || mv != 0) begin m_phase = P_RDY; m_left = IDLE; m_ds = 2; end
            end
            P_RDY: begin
                if (sp) begin m_phase = P_CNT; m_left = CNT; m_pm = 0; m_dm = 0; m_ds = 3; end
                else if (m_left == 0) begin m_phase = P_ATT; m_ds = 1; end
                else m_left--;
            end
            P_CNT: begin
                if (m_pm == 0) m_pm = mv;
                if (m_left == 0) begin
                    dp = m_lfsr % 3 + 1;
                    m_dm = dp; m_rv = 1; m_phase = P_RES; m_left = RES;
                    if (m_pm == 0) begin m_ds = 5; if (m_dsc < SMAX) m_dsc++; end
                    else if (m_pm == dp) m_ds = 4;
                    else if ((m_pm - dp + 3) % 3 == 1) begin m_ds = 7; if (m_psc < SMAX) m_psc++; end
                    else begin m_ds = 6; if (m_dsc < SMAX) m_dsc++; end
                end else m_left--;
            end
            P_RES: begin
                if (m_left == 0) begin
                    if (m_psc == SMAX || m_dsc == SMAX) begin
                        m_phase = P_OVR; m_ds = (m_psc == SMAX) ? 7 : 6;
                    end else begin
                        m_phase = P_RDY; m_left = IDLE; m_ds = 2;
                    end
                end else m_left--;
            end
            P_OVR: begin
                if (sp) begin m_psc = 0; m_dsc = 0; m_phase = P_RDY; m_left = IDLE; m_ds = 2; end
            end
            default: ;
        endcase
        pv_s = s; pv_r = r; pv_p = p; pv_x = x;
        m_lfsr = lfsr_adv(m_lfsr, 1);
    endtask

    // One clock: drive at the falling edge, step the model at the rising edge, compare at the next fall.
    task automatic cyc(input logic s, r, p, x, rs);
        bus.btn_start = s; bus.btn_rock = r; bus.btn_paper = p; bus.btn_scissors = x;
        rst = rs;
        @(posedge clk);
        model_step(s, r, p, x, rs);
        @(negedge clk);
        chk("doll_state",   int'(bus.doll_state),   m_ds);
        chk("player_move",  int'(bus.player_move),  m_pm);
        chk("doll_move",    int'(bus.doll_move),    m_dm);
        chk("player_score", int'(bus.player_score), m_psc);
        chk("doll_score",   int'(bus.doll_score),   m_dsc);
        chk("result_valid", int'(bus.result_valid), m_rv);
        if (bus.doll_state == 3'd3) n_ds3++;
        if (bus.result_valid) n_rv++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
    endtask

    task automatic run_count();
        for (int i = 0; i < 100 && bus.doll_state == 3'd3; i++) cyc(0, 0, 0, 0, 0);
        chk("count_bound", int'(bus.doll_state == 3'd3), 0);
    endtask

    // From READY with start released: start a round and press the move that beats the doll.
    task automatic play_win(input string tag);
        int d, w;
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        d = lfsr_adv(m_lfsr, m_left) % 3 + 1;
        w = d % 3 + 1;
        cyc(0, w == 1, w == 2, w == 3, 0);
        cyc(0, 0, 0, 0, 0);
        run_count();
        chk({tag, "_ds"}, int'(bus.doll_state), 7);
        chk({tag, "_pm"}, int'(bus.player_move), w);
        chk({tag, "_dm"}, int'(bus.doll_move), d);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        logic rs, rr, rp, rx, rrst;

        bus.btn_start = 1'b0; bus.btn_rock = 1'b0; bus.btn_paper = 1'b0; bus.btn_scissors = 1'b0;

        // Reset values
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        chk("rst_doll_state", int'(bus.doll_state), 1);
        chk("rst_player_move", int'(bus.player_move), 0);
        chk("rst_scores", int'({bus.player_score, bus.doll_score}), 0);
        chk("rst_result_valid", int'(bus.result_valid), 0);

        // Timeout round: COUNT lasts 21 cycles, one result pulse, doll point
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("attract_to_ready", int'(bus.doll_state), 2);
        cyc(0, 0, 0, 0, 0);
        n_ds3 = 0; n_rv = 0;
        cyc(1, 0, 0, 0, 0);
        run_count();
        chk("count_len", n_ds3, 21);
        chk("timeout_ds", int'(bus.doll_state), 5);
        chk("timeout_doll_score", int'(bus.doll_score), 1);
        idle(11);
        chk("rv_pulses", n_rv, 1);
        chk("result_to_ready", int'(bus.doll_state), 2);

        // Vector table: held levels, double press, first press latched
        tbl[0]  = '{0, 0, 0, 0, 1, 0};
        tbl[1]  = '{0, 1, 0, 0, 2, 0};
        tbl[2]  = '{0, 1, 0, 0, 2, 0};
        tbl[3]  = '{1, 0, 0, 0, 3, 0};
        tbl[4]  = '{0, 1, 0, 1, 3, 0};
        tbl[5]  = '{0, 0, 0, 0, 3, 0};
        tbl[6]  = '{0, 0, 0, 0, 3, 0};
        tbl[7]  = '{0, 0, 1, 0, 3, 2};
        tbl[8]  = '{0, 0, 0, 0, 3, 2};
        tbl[9]  = '{0, 1, 0, 0, 3, 2};
        tbl[10] = '{1, 0, 0, 0, 3, 2};
        tbl[11] = '{0, 0, 0, 0, 3, 2};
        do_reset();
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].s, tbl[i].r, tbl[i].p, tbl[i].x, 0);
            chk($sformatf("tbl%0d_ds", i), int'(bus.doll_state), tbl[i].ds);
            chk($sformatf("tbl%0d_pm", i), int'(bus.player_move), tbl[i].pm);
        end
        run_count();
        chk("latched_pm", int'(bus.player_move), 2);

        // Two player wins end the match; OVER holds through move presses
        do_reset();
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        play_win("win1");
        chk("win1_score", int'(bus.player_score), 1);
        idle(11);
        chk("win1_ready", int'(bus.doll_state), 2);
        play_win("win2");
        chk("win2_score", int'(bus.player_score), 2);
        idle(11);
        chk("over_ds", int'(bus.doll_state), 7);
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            cyc(0, (i % 20) == 5, 0, 0, 0);
            if (bus.doll_state != 3'd7) bad++;
        end
        chk("over_hold", bad, 0);
        cyc(1, 0, 0, 0, 0);
        chk("over_start_ds", int'(bus.doll_state), 2);
        chk("over_start_scores", int'({bus.player_score, bus.doll_score}), 0);

        // READY inactivity: 50 cycles stay, 51st falls back
        cyc(0, 0, 0, 0, 0);
        idle(49);
        chk("ready_50", int'(bus.doll_state), 2);
        idle(1);
        chk("ready_51", int'(bus.doll_state), 1);

        // Start held across reset is not a press
        cyc(1, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 0, 0);
        chk("held_start", int'(bus.doll_state), 1);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        chk("fresh_start", int'(bus.doll_state), 2);

        // Reset mid-COUNT after a scored round and a latched move
        cyc(0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0);
        run_count();
        chk("abort_prep_score", int'(bus.doll_score), 1);
        idle(11);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk("abort_pm_latched", int'(bus.player_move), 1);
        n_rv = 0;
        cyc(0, 0, 0, 0, 1);
        chk("abort_ds", int'(bus.doll_state), 1);
        chk("abort_pm", int'(bus.player_move), 0);
        chk("abort_scores", int'({bus.player_score, bus.doll_score}), 0);
        chk("abort_rv", n_rv, 0);

        // Random buttons against the model
        do_reset();
        rs = 0; rr = 0; rp = 0; rx = 0;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 9) == 0) rs = ~rs;
            if ($urandom_range(0, 5) == 0) rr = ~rr;
            if ($urandom_range(0, 5) == 0) rp = ~rp;
            if ($urandom_range(0, 5) == 0) rx = ~rx;
            rrst = ($urandom_range(0, 999) == 0);
            cyc(rs, rr, rp, rx, rrst);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
